// File: rtl/axi3_slave_mem.sv
// axi3_slave_mem: AXI3 responder in front of a word-addressed RAM.
// Handshake rule on every channel: a transfer happens on a rising ACLK edge
// where VALID and READY are both high; a source holds VALID and its payload
// stable until that edge, and READY never depends combinationally on VALID.
// Write and read sides each take one burst at a time and run independently.
// Only FIXED (00) and INCR (01) bursts at full bus width are honoured.
module axi3_slave_mem #(
    parameter int data_bus_width    = 32,
    parameter int address_bus_width = 32,
    parameter int id_bus_width      = 1,
    parameter int axi_len_width     = 8,
    parameter int mem_depth_log2    = 10
) (
    input  logic                          ACLK,
    input  logic                          ARESETn,
    input  logic                          AWVALID,
    output logic                          AWREADY,
    input  logic [id_bus_width-1:0]       AWID,
    input  logic [address_bus_width-1:0]  AWADDR,
    input  logic [axi_len_width-1:0]      AWLEN,
    input  logic [1:0]                    AWBURST,
    input  logic                          WVALID,
    output logic                          WREADY,
    input  logic [id_bus_width-1:0]       WID,
    input  logic [data_bus_width-1:0]     WDATA,
    input  logic [data_bus_width/8-1:0]   WSTRB,
    input  logic                          WLAST,
    output logic                          BVALID,
    input  logic                          BREADY,
    output logic [id_bus_width-1:0]       BID,
    output logic [1:0]                    BRESP,
    input  logic                          ARVALID,
    output logic                          ARREADY,
    input  logic [id_bus_width-1:0]       ARID,
    input  logic [address_bus_width-1:0]  ARADDR,
    input  logic [axi_len_width-1:0]      ARLEN,
    input  logic [1:0]                    ARBURST,
    output logic                          RVALID,
    input  logic                          RREADY,
    output logic [id_bus_width-1:0]       RID,
    output logic [data_bus_width-1:0]     RDATA,
    output logic [1:0]                    RRESP,
    output logic                          RLAST
);
    localparam int STRB_W = data_bus_width / 8;
    localparam int OFF    = $clog2(STRB_W);
    localparam int WA     = address_bus_width - OFF;
    localparam int DEPTH  = 1 << mem_depth_log2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_t;
    typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

    // FSM state is kept in named registers so checkers can bind to them.
    w_state_t w_state;
    r_state_t r_state;

    logic [data_bus_width-1:0] mem [DEPTH];

    // Write burst context; w_addr is a full word address so INCR can run
    // past the top of the RAM and be flagged out of range.
    logic [id_bus_width-1:0]  w_id;
    logic [WA-1:0]            w_addr;
    logic [axi_len_width-1:0] w_len;
    logic [axi_len_width-1:0] w_cnt;
    logic [1:0]               w_burst;
    logic [1:0]               w_resp;

    logic [WA-1:0]            r_addr;
    logic [axi_len_width-1:0] r_len;
    logic [axi_len_width-1:0] r_cnt;
    logic [1:0]               r_burst;

    // Byte-lane bits below the word index carry no information here.
    logic addr_lsb_unused;
    assign addr_lsb_unused = ^{AWADDR[OFF-1:0], ARADDR[OFF-1:0]};

    logic       w_beat, w_oor, w_unsup, w_at_len, w_done;
    logic [1:0] w_beat_resp, w_resp_nxt;

    // Classify the current write beat and fold it into the sticky response.
    always_comb begin
        w_beat   = (w_state == W_DATA) && WVALID && WREADY;
        w_oor    = (w_addr[WA-1:mem_depth_log2] != '0);
        w_unsup  = w_burst[1];
        w_at_len = (w_cnt == w_len);
        w_done   = w_at_len || WLAST;
        if (w_oor)
            w_beat_resp = RESP_DECERR;
        else if (w_unsup || (WID != w_id) || (WLAST != w_at_len))
            w_beat_resp = RESP_SLVERR;
        else
            w_beat_resp = RESP_OKAY;
        if ((w_resp == RESP_DECERR) || (w_beat_resp == RESP_DECERR))
            w_resp_nxt = RESP_DECERR;
        else if ((w_resp == RESP_SLVERR) || (w_beat_resp == RESP_SLVERR))
            w_resp_nxt = RESP_SLVERR;
        else
            w_resp_nxt = RESP_OKAY;
    end

    // Write channel FSM: AW accept, data beats, then hold B until taken.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            w_state <= W_IDLE;
            AWREADY <= 1'b1;
            WREADY  <= 1'b0;
            BVALID  <= 1'b0;
            BID     <= '0;
            BRESP   <= RESP_OKAY;
            w_id    <= '0;
            w_addr  <= '0;
            w_len   <= '0;
            w_cnt   <= '0;
            w_burst <= '0;
            w_resp  <= RESP_OKAY;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (AWVALID && AWREADY) begin
                        w_id    <= AWID;
                        w_addr  <= AWADDR[address_bus_width-1:OFF];
                        w_len   <= AWLEN;
                        w_burst <= AWBURST;
                        w_cnt   <= '0;
                        w_resp  <= RESP_OKAY;
                        AWREADY <= 1'b0;
                        WREADY  <= 1'b1;
                        w_state <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_beat) begin
                        w_resp <= w_resp_nxt;
                        if (w_done) begin
                            WREADY  <= 1'b0;
                            BVALID  <= 1'b1;
                            BID     <= w_id;
                            BRESP   <= w_resp_nxt;
                            w_state <= W_RESP;
                        end else begin
                            w_cnt <= w_cnt + axi_len_width'(1);
                            if (w_burst == BURST_INCR)
                                w_addr <= w_addr + WA'(1);
                        end
                    end
                end
                W_RESP: begin
                    if (BVALID && BREADY) begin
                        BVALID  <= 1'b0;
                        AWREADY <= 1'b1;
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // RAM write port: byte-enabled, suppressed for out-of-range or unsupported beats.
    always_ff @(posedge ACLK) begin
        if (w_beat && !w_oor && !w_unsup) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (WSTRB[b])
                    mem[w_addr[mem_depth_log2-1:0]][8*b +: 8] <= WDATA[8*b +: 8];
            end
        end
    end

    logic [WA-1:0]             rd_addr, r_addr_nxt;
    logic [1:0]                rd_burst, rd_resp;
    logic                      rd_oor, rd_unsup;
    logic [data_bus_width-1:0] rd_data;
    logic [axi_len_width-1:0]  r_cnt_nxt;

    // Address, data and response of the beat that will be presented next:
    // the first beat from AR while idle, otherwise the following beat.
    always_comb begin
        r_cnt_nxt  = r_cnt + axi_len_width'(1);
        r_addr_nxt = (r_burst == BURST_INCR) ? (r_addr + WA'(1)) : r_addr;
        if (r_state == R_IDLE) begin
            rd_addr  = ARADDR[address_bus_width-1:OFF];
            rd_burst = ARBURST;
        end else begin
            rd_addr  = r_addr_nxt;
            rd_burst = r_burst;
        end
        rd_oor   = (rd_addr[WA-1:mem_depth_log2] != '0);
        rd_unsup = rd_burst[1];
        rd_data  = (rd_oor || rd_unsup) ? '0 : mem[rd_addr[mem_depth_log2-1:0]];
        if (rd_oor)
            rd_resp = RESP_DECERR;
        else if (rd_unsup)
            rd_resp = RESP_SLVERR;
        else
            rd_resp = RESP_OKAY;
    end

    // Read channel FSM: AR accept, then one registered beat per R handshake.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state <= R_IDLE;
            ARREADY <= 1'b1;
            RVALID  <= 1'b0;
            RLAST   <= 1'b0;
            RID     <= '0;
            RDATA   <= '0;
            RRESP   <= RESP_OKAY;
            r_addr  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_burst <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ARVALID && ARREADY) begin
                        r_addr  <= rd_addr;
                        r_len   <= ARLEN;
                        r_burst <= ARBURST;
                        r_cnt   <= '0;
                        ARREADY <= 1'b0;
                        RVALID  <= 1'b1;
                        RID     <= ARID;
                        RDATA   <= rd_data;
                        RRESP   <= rd_resp;
                        RLAST   <= (ARLEN == '0);
                        r_state <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (RVALID && RREADY) begin
                        if (r_cnt == r_len) begin
                            RVALID  <= 1'b0;
                            RLAST   <= 1'b0;
                            ARREADY <= 1'b1;
                            r_state <= R_IDLE;
                        end else begin
                            r_cnt  <= r_cnt_nxt;
                            r_addr <= r_addr_nxt;
                            RDATA  <= rd_data;
                            RRESP  <= rd_resp;
                            RLAST  <= (r_cnt_nxt == r_len);
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi3_slave_mem.sv
// tb_axi3_slave_mem: directed vector table of write/read bursts against
// axi3_slave_mem, plus a hand-written mid-burst reset sequence.
module tb_axi3_slave_mem;
    logic        ACLK;
    logic        ARESETn;
    logic        AWVALID, AWREADY;
    logic [0:0]  AWID;
    logic [31:0] AWADDR;
    logic [7:0]  AWLEN;
    logic [1:0]  AWBURST;
    logic        WVALID, WREADY;
    logic [0:0]  WID;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WLAST;
    logic        BVALID, BREADY;
    logic [0:0]  BID;
    logic [1:0]  BRESP;
    logic        ARVALID, ARREADY;
    logic [0:0]  ARID;
    logic [31:0] ARADDR;
    logic [7:0]  ARLEN;
    logic [1:0]  ARBURST;
    logic        RVALID, RREADY;
    logic [0:0]  RID;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    axi3_slave_mem #(
        .data_bus_width(32), .address_bus_width(32), .id_bus_width(1),
        .axi_len_width(8), .mem_depth_log2(10)
    ) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWID(AWID), .AWADDR(AWADDR),
        .AWLEN(AWLEN), .AWBURST(AWBURST),
        .WVALID(WVALID), .WREADY(WREADY), .WID(WID), .WDATA(WDATA),
        .WSTRB(WSTRB), .WLAST(WLAST),
        .BVALID(BVALID), .BREADY(BREADY), .BID(BID), .BRESP(BRESP),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARID(ARID), .ARADDR(ARADDR),
        .ARLEN(ARLEN), .ARBURST(ARBURST),
        .RVALID(RVALID), .RREADY(RREADY), .RID(RID), .RDATA(RDATA),
        .RRESP(RRESP), .RLAST(RLAST)
    );

    // Clock and watchdog
    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string            name;
        bit               is_write;
        logic [0:0]       id;
        logic [31:0]      addr;
        logic [7:0]       len;
        logic [1:0]       burst;
        logic [3:0]       strb;
        logic [3:0][31:0] data;
        int               n_beats;
        int               last_at;
        bit               wid_flip;
        int               bready_delay;
        logic [1:0]       exp_bresp;
        logic [3:0][31:0] exp_rdata;
        logic [3:0][1:0]  exp_rresp;
        int               stall;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk_w(input string name, input logic [0:0] id,
                                  input logic [31:0] addr, input logic [7:0] len,
                                  input logic [1:0] burst, input logic [3:0] strb,
                                  input logic [3:0][31:0] data, input int n_beats,
                                  input int last_at, input bit wid_flip,
                                  input int bready_delay, input logic [1:0] bresp);
        vec_t v;
        v.name = name; v.is_write = 1'b1; v.id = id; v.addr = addr; v.len = len;
        v.burst = burst; v.strb = strb; v.data = data; v.n_beats = n_beats;
        v.last_at = last_at; v.wid_flip = wid_flip; v.bready_delay = bready_delay;
        v.exp_bresp = bresp; v.exp_rdata = '0; v.exp_rresp = '0; v.stall = 0;
        return v;
    endfunction

    function automatic vec_t mk_r(input string name, input logic [0:0] id,
                                  input logic [31:0] addr, input logic [7:0] len,
                                  input logic [1:0] burst, input logic [3:0][31:0] rdata,
                                  input logic [3:0][1:0] rresp, input int stall);
        vec_t v;
        v.name = name; v.is_write = 1'b0; v.id = id; v.addr = addr; v.len = len;
        v.burst = burst; v.strb = '0; v.data = '0; v.n_beats = 0; v.last_at = 0;
        v.wid_flip = 1'b0; v.bready_delay = 0; v.exp_bresp = '0;
        v.exp_rdata = rdata; v.exp_rresp = rresp; v.stall = stall;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    // Driver: one write burst, starting and ending on a negedge.
    task automatic do_write(input vec_t v);
        int n;
        AWID = v.id; AWADDR = v.addr; AWLEN = v.len; AWBURST = v.burst; AWVALID = 1'b1;
        n = 0;
        while (!AWREADY && n < 50) begin @(negedge ACLK); n++; end
        check({v.name, ".awready_wait"}, 32'(n), 32'd0);
        @(negedge ACLK);
        AWVALID = 1'b0;
        for (int b = 0; b < v.n_beats; b++) begin
            WVALID = 1'b1; WDATA = v.data[b]; WSTRB = v.strb;
            WID = v.wid_flip ? ~v.id : v.id;
            WLAST = (b == v.last_at);
            n = 0;
            while (!WREADY && n < 50) begin @(negedge ACLK); n++; end
            check({v.name, ".wready_wait"}, 32'(n), 32'd0);
            @(negedge ACLK);
        end
        WVALID = 1'b0; WLAST = 1'b0;
        check({v.name, ".wready_low_after"}, 32'(WREADY), 32'd0);
        n = 0;
        while (!BVALID && n < 50) begin @(negedge ACLK); n++; end
        check({v.name, ".bvalid_latency"}, 32'(n), 32'd0);
        for (int k = 0; k < v.bready_delay; k++) begin
            check({v.name, ".bvalid_hold"}, 32'(BVALID), 32'd1);
            check({v.name, ".bresp_hold"}, 32'(BRESP), 32'(v.exp_bresp));
            @(negedge ACLK);
        end
        BREADY = 1'b1;
        check({v.name, ".bresp"}, 32'(BRESP), 32'(v.exp_bresp));
        check({v.name, ".bid"}, 32'(BID), 32'(v.id));
        @(negedge ACLK);
        BREADY = 1'b0;
        check({v.name, ".bvalid_drop"}, 32'(BVALID), 32'd0);
        check({v.name, ".awready_back"}, 32'(AWREADY), 32'd1);
    endtask

    // Driver plus scoreboard: one read burst compared beat by beat.
    task automatic do_read(input vec_t v);
        int n;
        logic [31:0] exp_d;
        for (int b = 0; b <= int'(v.len); b++) exp_q.push_back(v.exp_rdata[b]);
        ARID = v.id; ARADDR = v.addr; ARLEN = v.len; ARBURST = v.burst; ARVALID = 1'b1;
        RREADY = (v.stall == 0);
        n = 0;
        while (!ARREADY && n < 50) begin @(negedge ACLK); n++; end
        check({v.name, ".arready_wait"}, 32'(n), 32'd0);
        @(negedge ACLK);
        ARVALID = 1'b0;
        for (int beat = 0; beat <= int'(v.len); beat++) begin
            n = 0;
            while (!RVALID && n < 50) begin @(negedge ACLK); n++; end
            check({v.name, ".rvalid_gap"}, 32'(n), 32'd0);
            if (beat == 0 && v.stall > 0) begin
                for (int k = 0; k < v.stall; k++) begin
                    check({v.name, ".stall_rvalid"}, 32'(RVALID), 32'd1);
                    check({v.name, ".stall_rdata"}, RDATA, exp_q[0]);
                    @(negedge ACLK);
                end
                RREADY = 1'b1;
            end
            exp_d = exp_q.pop_front();
            check({v.name, ".rdata"}, RDATA, exp_d);
            check({v.name, ".rresp"}, 32'(RRESP), 32'(v.exp_rresp[beat]));
            check({v.name, ".rlast"}, 32'(RLAST), (beat == int'(v.len)) ? 32'd1 : 32'd0);
            check({v.name, ".rid"}, 32'(RID), 32'(v.id));
            @(negedge ACLK);
        end
        RREADY = 1'b0;
        check({v.name, ".rvalid_drop"}, 32'(RVALID), 32'd0);
        check({v.name, ".arready_back"}, 32'(ARREADY), 32'd1);
    endtask

    // Main sequence: reset, vector table, mid-burst reset, report.
    initial begin
        int n;
        ARESETn = 1'b0;
        AWVALID = 0; AWID = 0; AWADDR = 0; AWLEN = 0; AWBURST = 0;
        WVALID = 0; WID = 0; WDATA = 0; WSTRB = 0; WLAST = 0; BREADY = 0;
        ARVALID = 0; ARID = 0; ARADDR = 0; ARLEN = 0; ARBURST = 0; RREADY = 0;

        vecs.push_back(mk_w("incr_wr", 1'b1, 32'h10, 8'd3, 2'b01, 4'hF,
                            {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 4, 3, 1'b0, 0, 2'b00));
        vecs.push_back(mk_r("incr_rd", 1'b1, 32'h10, 8'd3, 2'b01,
                            {32'hA3, 32'hA2, 32'hA1, 32'hA0}, {2'b00, 2'b00, 2'b00, 2'b00}, 0));
        vecs.push_back(mk_w("clr0_wr", 1'b0, 32'h0, 8'd0, 2'b01, 4'hF,
                            {32'h0, 32'h0, 32'h0, 32'h0}, 1, 0, 1'b0, 2, 2'b00));
        vecs.push_back(mk_w("strb_wr", 1'b0, 32'h0, 8'd0, 2'b01, 4'h5,
                            {32'h0, 32'h0, 32'h0, 32'hFFFFFFFF}, 1, 0, 1'b0, 0, 2'b00));
        vecs.push_back(mk_r("strb_rd_stall", 1'b0, 32'h0, 8'd0, 2'b01,
                            {32'h0, 32'h0, 32'h0, 32'h00FF00FF}, {2'b00, 2'b00, 2'b00, 2'b00}, 3));
        vecs.push_back(mk_w("fixed_wr", 1'b0, 32'h8, 8'd2, 2'b00, 4'hF,
                            {32'h0, 32'h3, 32'h2, 32'h1}, 3, 2, 1'b0, 0, 2'b00));
        vecs.push_back(mk_r("fixed_chk_rd", 1'b0, 32'h8, 8'd0, 2'b01,
                            {32'h0, 32'h0, 32'h0, 32'h3}, {2'b00, 2'b00, 2'b00, 2'b00}, 0));
        vecs.push_back(mk_w("top_wr", 1'b1, 32'hFF8, 8'd3, 2'b01, 4'hF,
                            {32'hB3, 32'hB2, 32'hB1, 32'hB0}, 4, 3, 1'b0, 0, 2'b11));
        vecs.push_back(mk_r("top_rd", 1'b1, 32'hFF8, 8'd3, 2'b01,
                            {32'h0, 32'h0, 32'hB1, 32'hB0}, {2'b11, 2'b11, 2'b00, 2'b00}, 0));
        vecs.push_back(mk_w("early_wlast_wr", 1'b0, 32'h20, 8'd3, 2'b01, 4'hF,
                            {32'h0, 32'h0, 32'hC1, 32'hC0}, 2, 1, 1'b0, 0, 2'b10));
        vecs.push_back(mk_r("early_wlast_rd", 1'b0, 32'h20, 8'd1, 2'b01,
                            {32'h0, 32'h0, 32'hC1, 32'hC0}, {2'b00, 2'b00, 2'b00, 2'b00}, 0));
        vecs.push_back(mk_w("unsup_wr", 1'b1, 32'h10, 8'd0, 2'b10, 4'hF,
                            {32'h0, 32'h0, 32'h0, 32'hDEADBEEF}, 1, 0, 1'b0, 0, 2'b10));
        vecs.push_back(mk_r("fixed_rd", 1'b0, 32'h10, 8'd1, 2'b00,
                            {32'h0, 32'h0, 32'hA0, 32'hA0}, {2'b00, 2'b00, 2'b00, 2'b00}, 0));
        vecs.push_back(mk_r("unsup_rd", 1'b1, 32'h10, 8'd0, 2'b10,
                            {32'h0, 32'h0, 32'h0, 32'h0}, {2'b00, 2'b00, 2'b00, 2'b10}, 0));
        vecs.push_back(mk_w("wid_wr", 1'b0, 32'h30, 8'd0, 2'b01, 4'hF,
                            {32'h0, 32'h0, 32'h0, 32'h12345678}, 1, 0, 1'b1, 0, 2'b10));
        vecs.push_back(mk_r("wid_rd", 1'b0, 32'h30, 8'd0, 2'b01,
                            {32'h0, 32'h0, 32'h0, 32'h12345678}, {2'b00, 2'b00, 2'b00, 2'b00}, 0));

        repeat (3) @(negedge ACLK);
        check("rst.awready", 32'(AWREADY), 32'd1);
        check("rst.arready", 32'(ARREADY), 32'd1);
        check("rst.wready", 32'(WREADY), 32'd0);
        check("rst.bvalid", 32'(BVALID), 32'd0);
        check("rst.rvalid", 32'(RVALID), 32'd0);
        check("rst.rlast", 32'(RLAST), 32'd0);
        check("rst.ids", {30'd0, BID, RID}, 32'd0);
        check("rst.resps", {28'd0, BRESP, RRESP}, 32'd0);
        check("rst.rdata", RDATA, 32'd0);
        ARESETn = 1'b1;
        @(negedge ACLK);

        foreach (vecs[i]) begin
            if (vecs[i].is_write) do_write(vecs[i]);
            else do_read(vecs[i]);
        end

        // Reset in the middle of a stalled read burst.
        ARID = 1'b1; ARADDR = 32'h10; ARLEN = 8'd3; ARBURST = 2'b01; ARVALID = 1'b1;
        RREADY = 1'b0;
        @(negedge ACLK);
        ARVALID = 1'b0;
        n = 0;
        while (!RVALID && n < 50) begin @(negedge ACLK); n++; end
        check("midrst.rvalid_before", 32'(RVALID), 32'd1);
        check("midrst.rdata_before", RDATA, 32'hA0);
        #2 ARESETn = 1'b0;
        #1;
        check("midrst.rvalid", 32'(RVALID), 32'd0);
        check("midrst.arready", 32'(ARREADY), 32'd1);
        check("midrst.rdata", RDATA, 32'd0);
        @(negedge ACLK);
        ARESETn = 1'b1;
        @(negedge ACLK);
        do_read(mk_r("post_rst_rd", 1'b1, 32'h10, 8'd3, 2'b01,
                     {32'hA3, 32'hA2, 32'hA1, 32'hA0}, {2'b00, 2'b00, 2'b00, 2'b00}, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/axi3_slave_mem.md
Name: axi3_slave_mem

Overview:
Synthesizable AXI3 slave (responder) backed by an internal word-addressed RAM. It is the far end of our AXI3 master BFM in block-level benches, and it can stand in as a scratch memory on a GP port. Independent write and read channels each accept one outstanding burst. Only FIXED and INCR bursts and full-bus-width transfers are supported; there are no SIZE ports.

Parameters:
data_bus_width, 32, RDATA/WDATA width (power of 2, ≥32)
address_bus_width, 32, AWADDR/ARADDR width
id_bus_width, 1, width of AWID/WID/BID/ARID/RID
axi_len_width, 8, AWLEN/ARLEN width; a burst has LEN+1 beats
mem_depth_log2, 10, RAM has 2**mem_depth_log2 words

Ports:
ACLK  in  1  clock
ARESETn  in  1  asynchronous active-low reset
AWVALID  in  1  write address valid
AWREADY  out  1  write address ready
AWID  in  id_bus_width  write ID
AWADDR  in  address_bus_width  write byte address
AWLEN  in  axi_len_width  write beats-1
AWBURST  in  2  00 FIXED, 01 INCR, 10/11 unsupported
WVALID  in  1  write data valid
WREADY  out  1  write data ready
WID  in  id_bus_width  write data ID
WDATA  in  data_bus_width  write data
WSTRB  in  data_bus_width/8  byte enables
WLAST  in  1  last write beat
BVALID  out  1  write response valid
BREADY  in  1  write response ready
BID  out  id_bus_width  response ID (=latched AWID)
BRESP  out  2  00 OKAY, 10 SLVERR, 11 DECERR
ARVALID  in  1  read address valid
ARREADY  out  1  read address ready
ARID  in  id_bus_width  read ID
ARADDR  in  address_bus_width  read byte address
ARLEN  in  axi_len_width  read beats-1
ARBURST  in  2  as AWBURST
RVALID  out  1  read data valid
RREADY  in  1  read data ready
RID  out  id_bus_width  read ID (=latched ARID)
RDATA  out  data_bus_width  read data
RRESP  out  2  per-beat response
RLAST  out  1  last read beat

Behaviour:
- Reset (async, ARESETn=0): AWREADY=1, ARREADY=1, WREADY=0, BVALID=0, RVALID=0, RLAST=0. BID, RID, BRESP, RRESP and RDATA are 0. Both FSMs return to IDLE. RAM contents are not reset. A reset mid-burst abandons the burst immediately.
- Word index = addr[log2(B)+mem_depth_log2-1 : log2(B)], where B = data_bus_width/8. The low log2(B) address bits are ignored. Any nonzero bit above the index marks the beat as out of range.
- Write FSM, W_IDLE/W_DATA/W_RESP:
  - W_IDLE: AWREADY=1. On AWVALID&AWREADY, latch ID, index, LEN and BURST; set AWREADY<=0, WREADY<=1; go to W_DATA.
  - W_DATA: each WVALID&WREADY beat writes the RAM at the current index, byte-enabled by WSTRB, only if the beat is in range and the burst is supported. INCR increments the index; the increment is not masked, so running past the top makes later beats out of range. FIXED holds the index. Beats are counted 0..LEN.
  - Leaving W_DATA: when the beat count reaches LEN or WLAST=1, set WREADY<=0, BVALID<=1 and go to W_RESP.
  - Sticky response, highest priority first:
    - DECERR: any beat out of range.
    - SLVERR: burst unsupported (no RAM write), any WID≠AWID, or WLAST not coincident with beat LEN.
    - OKAY otherwise.
  - W_RESP: hold BVALID, BID and BRESP stable until BREADY. On BVALID&BREADY, set BVALID<=0 and AWREADY<=1 (next cycle), and go to W_IDLE.
- Read FSM, R_IDLE/R_DATA:
  - R_IDLE: ARREADY=1. On handshake, set ARREADY<=0 and RVALID<=1. RDATA<=RAM[index], or 0 if the beat is out of range or the burst is unsupported. RLAST<=(ARLEN==0). First RVALID is one cycle after the AR handshake.
  - R_DATA: RDATA, RRESP, RID and RLAST stay stable while RVALID&!RREADY. On RVALID&RREADY, advance to the next beat (one beat per cycle when RREADY is held high). On the last beat, set RVALID<=0, RLAST<=0, ARREADY<=1, and go to R_IDLE.
  - RRESP is per beat: DECERR if out of range, else SLVERR if the burst is unsupported, else OKAY.
- The two channels are fully independent. A read of a word in the same cycle as a write to that word returns the old data.

Test Plan:
- Reset, then INCR write: AWADDR=0x10, AWLEN=3, data 0xA0..0xA3, WSTRB=0xF, BREADY=1 → WREADY high 4 cycles, BRESP=00 with BID=AWID. INCR read of the same address, LEN=3, RREADY=1 → 0xA0..0xA3 on consecutive cycles, RLAST on 4th beat only, RRESP=00.
- Write 0xFFFFFFFF to 0x0 with WSTRB=0x5 over prior 0x0 → read returns 0x00FF00FF. Hold RREADY=0 for 3 cycles → RVALID/RDATA stable throughout.
- FIXED write to 0x8: LEN=2, data 1,2,3 → read of 0x8 returns 3.
- INCR write to word index 1022 (0xFF8), LEN=3 → beats 0–1 written, BRESP=11. Read of the same range → RRESP 00,00,11,11 and RDATA of beats 2–3 = 0.
- Write with WLAST on beat 1 of LEN=3 → BRESP=10 after that beat. AWBURST=10 write → BRESP=10, RAM unchanged.
- Assert ARESETn=0 mid read burst → RVALID=0, ARREADY=1 immediately. A new read after release returns the prior RAM contents.
